// File: rtl/mul_rr_scheduler.sv
// Round-robin scheduler sharing one combinational complex multiplier among N_REQ requesters,
// with valid/ready request and response handshakes and registered operands and result.

module mul
(
    input  logic [7:0]  in1,
    input  logic [7:0]  in2,
    output logic [15:0] out
);
    // Operands are signed 4-bit {re,im} pairs; results are 8-bit {re,im}, truncated bit-exact.
    logic signed [7:0] a_re, a_im, b_re, b_im;

    assign a_re = {{4{in1[7]}}, in1[7:4]};
    assign a_im = {{4{in1[3]}}, in1[3:0]};
    assign b_re = {{4{in2[7]}}, in2[7:4]};
    assign b_im = {{4{in2[3]}}, in2[3:0]};

    assign out = {a_re * b_re - a_im * b_im, a_re * b_im + a_im * b_re};
endmodule

module mul_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_in1,
    input  logic [8*N_REQ-1:0]   req_in2,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [15:0]          rsp_data,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic                 busy,
    output logic [CNT_W-1:0]     txn_count
);
    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   rr_ptr, gid, winner, gid_inc;
    logic [7:0]         op1, op2, sel_in1, sel_in2;
    logic [15:0]        res, mul_out;
    logic [CNT_W-1:0]   cnt;
    logic               found, rsp_hs;
    int                 scan_idx;

    mul u_mul (
        .in1 (op1),
        .in2 (op2),
        .out (mul_out)
    );

    // Scan from rr_ptr upward, wrapping explicitly at N_REQ; first valid requester wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = PTR_W'(scan_idx);
            end
        end
    end

    always_comb begin
        sel_in1 = '0;
        sel_in2 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == PTR_W'(i)) begin
                sel_in1 = req_in1[8*i +: 8];
                sel_in2 = req_in2[8*i +: 8];
            end
        end
    end

    assign gid_inc = (gid == PTR_W'(N_REQ - 1)) ? '0 : gid + PTR_W'(1);
    assign rsp_hs  = (state == RESP) && rsp_ready[gid];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found)  state_next = EXEC;
            EXEC:                state_next = RESP;
            RESP:    if (rsp_hs) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gid    <= '0;
            op1    <= '0;
            op2    <= '0;
            res    <= '0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && found) begin
                op1 <= sel_in1;
                op2 <= sel_in2;
                gid <= winner;
            end
            if (state == EXEC) res <= mul_out;
            if (rsp_hs) begin
                rr_ptr <= gid_inc;
                cnt    <= cnt + CNT_W'(1);
            end
        end
    end

    // Outputs are forced to zero while rst is asserted, not just after the reset edge.
    assign req_ready = (!rst && state == IDLE && found) ? (N_REQ'(1) << winner) : '0;
    assign rsp_valid = (!rst && state == RESP) ? (N_REQ'(1) << gid) : '0;
    assign rsp_data  = (!rst && state == RESP) ? res : '0;
    assign busy      = !rst && (state != IDLE);
    assign txn_count = rst ? '0 : cnt;
endmodule
